// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-port data BRAM between the exec-stage load/store path
// (port A) and the UART loader (port B). Each port issues a one-cycle request
// pulse and receives a one-cycle done pulse; one transaction per port may be
// outstanding. Requests are latched into a per-port slot, granted round-robin
// on ties, and sequenced as one-cycle writes or fixed-latency reads.
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   x_req/x_we/x_addr/x_wdata      request pulse + payload (x_we=0000 is a read)
//   x_done/x_rdata                 completion pulse, read data valid with done
//   mem_addr/mem_wdata/mem_wea     BRAM address, write data, byte enables
//   mem_enable                     BRAM enable, tied high
//   mem_rdata                      BRAM read data, READ_LAT cycles after address
//   busy                           request pending or transaction in flight
//   proto_err                      sticky: request while same port pending/active
module mem_port_arbiter #(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned AW       = 19
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          a_req,
    input  logic [3:0]    a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_done,
    output logic [31:0]   a_rdata,
    input  logic          b_req,
    input  logic [3:0]    b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    output logic          b_done,
    output logic [31:0]   b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wea,
    output logic          mem_enable,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic          proto_err
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } slot_t;

    state_t        state, state_n;
    slot_t         slot_a, slot_a_n, slot_b, slot_b_n, issue;
    logic          pend_a, pend_a_n, pend_b, pend_b_n;
    logic          cur_b, cur_b_n;
    logic          last_b, last_b_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] mem_addr_n;
    logic [31:0]   mem_wdata_n;
    logic [3:0]    mem_wea_n;
    logic          a_done_n, b_done_n;
    logic [31:0]   a_rdata_n, b_rdata_n;
    logic          busy_n, proto_err_n;
    logic          active_a, active_b, err_a, err_b, can_issue, pick_b;

    assign mem_enable = 1'b1;

    // Next-state: request latch, completion, and grant in one pass so a
    // request can be granted on the same edge that latches it.
    always_comb begin
        state_n     = state;
        slot_a_n    = slot_a;
        slot_b_n    = slot_b;
        pend_a_n    = pend_a;
        pend_b_n    = pend_b;
        cur_b_n     = cur_b;
        last_b_n    = last_b;
        cnt_n       = cnt;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_wea_n   = 4'b0000;
        a_done_n    = 1'b0;
        b_done_n    = 1'b0;
        a_rdata_n   = a_rdata;
        b_rdata_n   = b_rdata;
        issue       = '0;
        can_issue   = 1'b0;

        active_a = (state != IDLE) && !cur_b;
        active_b = (state != IDLE) && cur_b;
        err_a    = a_req && (pend_a || active_a);
        err_b    = b_req && (pend_b || active_b);

        if (a_req && !err_a) begin
            slot_a_n = {a_we, a_addr, a_wdata};
            pend_a_n = 1'b1;
        end
        if (b_req && !err_b) begin
            slot_b_n = {b_we, b_addr, b_wdata};
            pend_b_n = 1'b1;
        end
        proto_err_n = proto_err | err_a | err_b;

        // Completion edges double as issue edges for back-to-back service.
        unique case (state)
            IDLE: can_issue = 1'b1;
            WRITE: begin
                state_n   = IDLE;
                can_issue = 1'b1;
                if (cur_b) b_done_n = 1'b1;
                else       a_done_n = 1'b1;
            end
            READ_WAIT: begin
                if (cnt == '0) begin
                    state_n   = IDLE;
                    can_issue = 1'b1;
                    if (cur_b) begin
                        b_done_n  = 1'b1;
                        b_rdata_n = mem_rdata;
                    end else begin
                        a_done_n  = 1'b1;
                        a_rdata_n = mem_rdata;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // On a tie the port that did not win the previous tie goes first.
        pick_b = pend_b_n && (!pend_a_n || !last_b);
        if (can_issue && (pend_a_n || pend_b_n)) begin
            if (pend_a_n && pend_b_n) last_b_n = pick_b;
            issue = pick_b ? slot_b_n : slot_a_n;
            if (pick_b) pend_b_n = 1'b0;
            else        pend_a_n = 1'b0;
            cur_b_n     = pick_b;
            mem_addr_n  = issue.addr;
            mem_wdata_n = issue.wdata;
            mem_wea_n   = issue.we;
            state_n     = (issue.we != 4'b0000) ? WRITE : READ_WAIT;
            cnt_n       = CW'(READ_LAT);
        end

        busy_n = pend_a_n | pend_b_n | (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            slot_a    <= '0;
            slot_b    <= '0;
            pend_a    <= 1'b0;
            pend_b    <= 1'b0;
            cur_b     <= 1'b0;
            last_b    <= 1'b1;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wea   <= 4'b0000;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            slot_a    <= slot_a_n;
            slot_b    <= slot_b_n;
            pend_a    <= pend_a_n;
            pend_b    <= pend_b_n;
            cur_b     <= cur_b_n;
            last_b    <= last_b_n;
            cnt       <= cnt_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_wea   <= mem_wea_n;
            a_done    <= a_done_n;
            b_done    <= b_done_n;
            a_rdata   <= a_rdata_n;
            b_rdata   <= b_rdata_n;
            busy      <= busy_n;
            proto_err <= proto_err_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter
// Directed scenarios plus random traffic on both ports, every output compared
// each cycle against a transaction-timing reference model, with a small
// READ_LAT-pipelined BRAM model attached to the memory port.
module tb_mem_port_arbiter;

    localparam int unsigned READ_LAT = 2;
    localparam int unsigned AW       = 19;

    logic          clk = 1'b0;
    logic          rstn;
    logic          a_req, b_req;
    logic [3:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [31:0]   a_wdata, b_wdata;
    logic          a_done, b_done;
    logic [31:0]   a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wea;
    logic          mem_enable;
    logic [31:0]   mem_rdata;
    logic          busy, proto_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LAT(READ_LAT), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wea(mem_wea),
        .mem_enable(mem_enable), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    // BRAM model: 32 words, byte-enabled writes, READ_LAT-cycle read pipeline.
    logic [31:0]   seed_mem [32];
    logic          preload;
    logic [31:0]   bram [32];
    logic [AW-1:0] rd_pipe [READ_LAT];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) bram[i] <= seed_mem[i];
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wea[b]) bram[mem_addr[4:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd_pipe[0] <= mem_addr;
        for (int i = 1; i < int'(READ_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = bram[rd_pipe[READ_LAT-1][4:0]];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: tracks per-port pending requests, the edge at which
    // the BRAM frees up, and the cycle in which each completion is due.
    typedef struct {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
    } mreq_t;

    logic [31:0]   ref_mem [32];
    mreq_t         m_slot [2];
    bit            m_pend [2];
    bit            m_last;
    bit            m_cur;
    int            m_gt, m_free;
    int            m_done_cyc [2];
    bit            m_done_rd [2];
    logic [31:0]   m_done_val [2];
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;
    logic [3:0]    e_wea;
    bit            e_done [2];
    logic [31:0]   e_rdata [2];
    bit            e_busy, e_perr;

    task automatic model_edge();
        int    e;
        int    g;
        bit    rq [2];
        mreq_t in [2];
        mreq_t r;
        e = cyc;
        cyc++;
        rq[0] = a_req; in[0] = '{a_we, a_addr, a_wdata};
        rq[1] = b_req; in[1] = '{b_we, b_addr, b_wdata};
        if (!rstn) begin
            e_addr = '0; e_wdata = '0; e_wea = '0; e_busy = 0; e_perr = 0;
            m_last = 1; m_cur = 0; m_gt = -10; m_free = -10;
            for (int p = 0; p < 2; p++) begin
                m_pend[p] = 0; m_done_cyc[p] = -1; m_done_rd[p] = 0;
                e_done[p] = 0; e_rdata[p] = '0;
            end
            return;
        end
        for (int p = 0; p < 2; p++) begin
            e_done[p] = (m_done_cyc[p] == e + 1);
            if (e_done[p] && m_done_rd[p]) e_rdata[p] = m_done_val[p];
        end
        for (int p = 0; p < 2; p++) begin
            if (rq[p]) begin
                if (m_pend[p] || (int'(m_cur) == p && m_gt < e && e <= m_free)) e_perr = 1;
                else begin
                    m_pend[p] = 1;
                    m_slot[p] = in[p];
                end
            end
        end
        e_wea = 4'h0;
        if (e >= m_free && (m_pend[0] || m_pend[1])) begin
            if (m_pend[0] && m_pend[1]) begin
                g = m_last ? 0 : 1;
                m_last = (g == 1);
            end else begin
                g = m_pend[1] ? 1 : 0;
            end
            r = m_slot[g];
            m_pend[g] = 0;
            m_cur = (g == 1);
            m_gt = e;
            e_addr = r.addr; e_wdata = r.wd; e_wea = r.we;
            if (r.we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (r.we[b]) ref_mem[r.addr[4:0]][8*b +: 8] = r.wd[8*b +: 8];
                m_free = e + 1;
                m_done_cyc[g] = e + 2;
                m_done_rd[g] = 0;
            end else begin
                m_free = e + 1 + int'(READ_LAT);
                m_done_cyc[g] = e + 2 + int'(READ_LAT);
                m_done_rd[g] = 1;
                m_done_val[g] = ref_mem[r.addr[4:0]];
            end
        end
        e_busy = m_pend[0] || m_pend[1] || (e + 1 <= m_free);
    endtask

    task automatic compare_all();
        check("mem_addr",   32'(mem_addr),   32'(e_addr));
        check("mem_wdata",  mem_wdata,       e_wdata);
        check("mem_wea",    32'(mem_wea),    32'(e_wea));
        check("mem_enable", 32'(mem_enable), 32'd1);
        check("a_done",     32'(a_done),     32'(e_done[0]));
        check("b_done",     32'(b_done),     32'(e_done[1]));
        check("a_rdata",    a_rdata,         e_rdata[0]);
        check("b_rdata",    b_rdata,         e_rdata[1]);
        check("busy",       32'(busy),       32'(e_busy));
        check("proto_err",  32'(proto_err),  32'(e_perr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        a_req = 0; b_req = 0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        a_req = 0; b_req = 0; rstn = 0;
        step();
        rstn = 1;
    endtask

    initial begin
        int na, nb, nd, prev;
        rstn = 0; preload = 1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < 32; i++) seed_mem[i] = $urandom;
        seed_mem[16] = 32'h1234_5678;
        for (int i = 0; i < 32; i++) ref_mem[i] = seed_mem[i];
        repeat (3) step();
        preload = 0; rstn = 1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Single read on B
        b_req = 1; b_we = 4'h0; b_addr = 19'h10; step(); b_req = 0;
        check("rd_c1_addr", 32'(mem_addr), 32'h10);
        step(); step();
        check("rd_c3_nodone", 32'(b_done), 32'd0);
        step();
        check("rd_c4_done", 32'(b_done), 32'd1);
        check("rd_c4_data", b_rdata, 32'h1234_5678);
        check("rd_c4_no_a", 32'(a_done), 32'd0);
        idle(4);

        // Single write on A
        a_req = 1; a_we = 4'hF; a_addr = 19'h10; a_wdata = 32'hDEAD_BEEF; step(); a_req = 0;
        check("wr_c1_addr", 32'(mem_addr), 32'h10);
        check("wr_c1_wea", 32'(mem_wea), 32'hF);
        check("wr_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        check("wr_c2_done", 32'(a_done), 32'd1);
        check("wr_c2_wea", 32'(mem_wea), 32'd0);
        idle(4);

        // Simultaneous after reset: A wins, B follows back-to-back
        do_reset();
        a_req = 1; a_we = 4'hF; a_addr = 19'h1; a_wdata = $urandom;
        b_req = 1; b_we = 4'h0; b_addr = 19'h2;
        step(); a_req = 0; b_req = 0;
        check("sim_c1_addr", 32'(mem_addr), 32'h1);
        step();
        check("sim_c2_adone", 32'(a_done), 32'd1);
        check("sim_c2_addr", 32'(mem_addr), 32'h2);
        step(); step();
        check("sim_c4_bdone", 32'(b_done), 32'd0);
        step();
        check("sim_c5_bdone", 32'(b_done), 32'd1);
        idle(4);

        // Round-robin: both ports keep re-requesting in their done cycle
        a_req = 1; a_we = 4'h0; a_addr = 19'h3;
        b_req = 1; b_we = 4'h0; b_addr = 19'h4;
        na = 0; nb = 0; nd = 0; prev = -1;
        for (int k = 0; k < 200 && nd < 8; k++) begin
            step();
            a_req = a_done; b_req = b_done;
            if (a_done || b_done) begin
                int p;
                p = b_done ? 1 : 0;
                if (prev >= 0) check("rr_alternate", 32'(p != prev), 32'd1);
                prev = p;
                nd++;
                if (p == 1) nb++; else na++;
            end
        end
        check("rr_count", 32'(nd), 32'd8);
        check("rr_fair_a", 32'(na), 32'd4);
        idle(12);

        // Protocol error: second request while active is dropped
        do_reset();
        a_req = 1; a_we = 4'hF; a_addr = 19'h5; a_wdata = $urandom;
        step();
        check("perr_c1", 32'(proto_err), 32'd0);
        step(); a_req = 0;
        check("perr_c2", 32'(proto_err), 32'd1);
        na = a_done ? 1 : 0;
        repeat (8) begin
            step();
            if (a_done) na++;
        end
        check("perr_sticky", 32'(proto_err), 32'd1);
        check("perr_one_done", 32'(na), 32'd1);

        // Reset mid-read abandons the transaction
        do_reset();
        b_req = 1; b_we = 4'h0; b_addr = 19'h6; step(); b_req = 0;
        step();
        rstn = 0; step(); rstn = 1;
        check("rmr_mem_addr", 32'(mem_addr), 32'd0);
        check("rmr_busy", 32'(busy), 32'd0);
        check("rmr_b_rdata", b_rdata, 32'd0);
        nb = 0;
        repeat (8) begin
            step();
            if (b_done) nb++;
        end
        check("rmr_no_bdone", 32'(nb), 32'd0);
        a_req = 1; a_we = 4'h0; a_addr = 19'h7; step(); a_req = 0;
        repeat (3) step();
        check("rmr_a_done", 32'(a_done), 32'd1);
        idle(4);

        // Random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            rstn    = ($urandom_range(0, 149) != 0);
            a_req   = ($urandom_range(0, 3) == 0);
            a_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            a_addr  = 19'($urandom_range(0, 31));
            a_wdata = $urandom;
            b_req   = ($urandom_range(0, 3) == 0);
            b_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            b_addr  = 19'($urandom_range(0, 31));
            b_wdata = $urandom;
            step();
        end
        rstn = 1;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data BRAM between two requesters: the exec stage's load/store path (port A) and the UART program/data loader (port B).
- Each requester uses a pulse request / pulse done handshake, with at most one transaction outstanding per port.
- The block latches requests, grants the BRAM round-robin, sequences fixed-latency reads and one-cycle writes, and returns read data with a done pulse.

Parameters:
- READ_LAT, 2, cycles from the address cycle until mem_rdata is valid (1..7).
- AW, 19, BRAM word-address width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- a_req  in  1  port A request pulse, 1 cycle
- a_we  in  4  port A byte write enables; 0000 = read
- a_addr  in  AW  port A word address
- a_wdata  in  32  port A write data
- a_done  out  1  port A completion pulse
- a_rdata  out  32  port A read data, valid with a_done
- b_req, b_we, b_addr, b_wdata, b_done, b_rdata  same as port A, for port B
- mem_addr  out  AW  BRAM address
- mem_wdata  out  32  BRAM write data
- mem_wea  out  4  BRAM byte write enables
- mem_enable  out  1  BRAM enable, constant 1
- mem_rdata  in  32  BRAM read data
- busy  out  1  transaction in flight or pending
- proto_err  out  1  sticky: request received while the same port was already pending or active

Behaviour:
- Reset (rstn=0 at posedge):
  - clears all pending and active state, counter and last_grant (last_grant=B, so A wins the first tie).
  - drives mem_addr=0, mem_wdata=0, mem_wea=0000, a/b_done=0, a/b_rdata=0, busy=0, proto_err=0.
  - A reset mid-operation abandons the transaction: no done is ever produced for it.
- Request latch:
  - At each posedge with x_req=1, {we, addr, wdata} are captured into slot x and pend_x is set.
  - If pend_x or active_x is already set, the request is dropped and proto_err is set.
- States: IDLE, WRITE, READ_WAIT. All outputs are registered.
- Grant (IDLE, evaluated at a posedge, including the one that latches a request):
  - Candidates are pending slots plus same-edge requests.
  - Single candidate: it is granted.
  - Both candidates: the port other than last_grant is granted, then last_grant is updated.
  - Granting drives mem_addr, mem_wdata, mem_wea from the slot and clears its pending bit.
- Latency from request: a request sampled at cycle 0 with the arbiter idle puts its address on the BRAM in cycle 1.
- WRITE:
  - mem_wea is nonzero for exactly cycle 1, then 0000.
  - x_done is pulsed in cycle 2.
  - The state is IDLE again at the end of cycle 1, so a pending request can issue in cycle 2.
- READ_WAIT:
  - mem_wea=0000 and the counter is loaded with READ_LAT.
  - mem_rdata is sampled at the end of cycle 1+READ_LAT.
  - x_rdata and x_done are presented in cycle 2+READ_LAT.
  - Return to IDLE is on that same capture edge, so the next address can issue in cycle 2+READ_LAT.
- Output hold rules:
  - mem_addr and mem_wdata hold their last value when idle.
  - x_rdata holds until the next read completion for that port.
  - x_done is high for exactly one cycle per accepted request.
- Write data is not transformed: the requester supplies byte-replicated data for byte stores.
- A request from the port currently being completed is legal in its done cycle; the slot is already free.
- busy = pend_a | pend_b | state!=IDLE.

Test Plan:
- Single write: a_req, a_we=1111, a_addr=0x00010, a_wdata=0xDEADBEEF at cycle 0 -> cycle 1 mem_addr=0x00010, mem_wea=1111, mem_wdata=0xDEADBEEF; cycle 2 a_done=1, mem_wea=0000.
- Single read, READ_LAT=2, BRAM model holding 0x12345678 at 0x00010: b_req read at cycle 0 -> mem_addr=0x00010 in cycle 1; b_done=1 and b_rdata=0x12345678 in cycle 4; no a_done.
- Simultaneous requests after reset: a write to 0x1 and b read of 0x2 at cycle 0 -> A issues cycle 1, a_done cycle 2; B issues cycle 2, b_done cycle 5.
- Round-robin: repeated simultaneous reads on both ports, each port re-requesting in its done cycle -> grants alternate A,B,A,B; neither port is starved.
- Protocol error: a_req at cycle 0 and again at cycle 1 while active -> second request dropped, proto_err=1 from cycle 2 and stays high, exactly one a_done.
- Reset mid-read: b read at cycle 0, rstn=0 in cycle 2 -> b_done never asserts; all outputs zero after reset; a following a_req completes normally.
